// File: rtl/pc_controller.sv
// pc_controller: next-PC sequencer merging stalls, redirects and halt/resume; PC_PERF_COUNTERS_EN enables perf counters
module pc_controller #(
  parameter int ADDR_WIDTH       = 32,
  parameter int REDIRECT_BUBBLES = 1
) (
  input  logic                  clock_i,
  input  logic                  reset_ni,
  input  logic [ADDR_WIDTH-1:0] current_pc_i,
  input  logic                  stall_request_i,
  input  logic                  branch_taken_i,
  input  logic [ADDR_WIDTH-1:0] branch_target_i,
  input  logic                  jump_valid_i,
  input  logic [ADDR_WIDTH-1:0] jump_target_i,
  input  logic                  halt_request_i,
  input  logic                  resume_i,
  output logic                  control_use_npc_o,
  output logic [ADDR_WIDTH-1:0] data_jump_address_o,
  output logic                  flush_o,
  output logic                  fetch_valid_o,
  output logic                  halted_o,
  output logic [31:0]           stall_cycles_o,
  output logic [31:0]           redirect_count_o
);
  typedef enum logic [1:0] {RUN, REDIRECT, HALT} state_e;
  state_e state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic halt_st, redir, stall_hold;
  logic [ADDR_WIDTH-1:0] target;
  // control outputs settle combinationally before the pc register's negedge; reset forces safe values
  always_comb begin
    halt_st = state_q == HALT;
    redir = !halt_st && (branch_taken_i || jump_valid_i);
    stall_hold = !halt_st && !redir && stall_request_i;
    target = branch_taken_i ? branch_target_i : jump_target_i;
    control_use_npc_o = reset_ni && !halt_st && !redir && !stall_hold;
    data_jump_address_o = !reset_ni ? '0 : (halt_st || stall_hold) ? current_pc_i : redir ? target : '0;
    flush_o = !reset_ni || halt_st || redir || state_q == REDIRECT;
    fetch_valid_o = reset_ni && state_q == RUN && !redir && !stall_request_i;
    halted_o = reset_ni && halt_st;
  end
  // next state: halt/resume first, then redirect reload, then bubble countdown
  always_comb begin
    state_d = state_q;
    cnt_d = '0;
    if (halt_st) state_d = resume_i ? RUN : HALT;
    else if (halt_request_i) state_d = HALT;
    else if (redir) begin
      state_d = REDIRECT_BUBBLES > 1 ? REDIRECT : RUN;
      cnt_d = 4'(REDIRECT_BUBBLES - 1);
    end else if (state_q == REDIRECT) begin
      state_d = cnt_q == 4'd1 ? RUN : REDIRECT;
      cnt_d = cnt_q - 4'd1;
    end else state_d = RUN;
  end
  // state and bubble counter registers
  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= RUN;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
    end
  end
`ifdef PC_PERF_COUNTERS_EN
  logic [31:0] stall_q, redir_q;
  // saturating counts of stall-held cycles and applied redirects
  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      stall_q <= '0;
      redir_q <= '0;
    end else begin
      if (stall_hold && ~&stall_q) stall_q <= stall_q + 32'd1;
      if (redir && ~&redir_q) redir_q <= redir_q + 32'd1;
    end
  end
  assign stall_cycles_o = stall_q;
  assign redirect_count_o = redir_q;
`else
  assign stall_cycles_o = '0;
  assign redirect_count_o = '0;
`endif
endmodule

// File: tb/tb_pc_controller.sv
// tb_pc_controller: directed scenarios with a behavioural next-PC model checked every cycle
module tb_pc_controller;
  localparam int RB = 3;
`ifdef PC_PERF_COUNTERS_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif
  logic clock = 1'b0, reset_n = 1'b0;
  logic [31:0] pc = '0, bt = '0, jt = '0;
  logic stall = 1'b0, br = 1'b0, jv = 1'b0, hr = 1'b0, resume = 1'b0;
  logic use_npc, flush, fv, halted;
  logic [31:0] addr, stall_cycles, redirect_count;
  int errors = 0, checks = 0;
  bit m_halt = 0, n_halt = 0, inc_s = 0, inc_r = 0;
  int m_bub = 0, n_bub = 0;
  logic [31:0] e_stall = '0, e_red = '0, e_addr;
  logic e_use, e_flush, e_fv, e_halted;

  pc_controller #(.ADDR_WIDTH(32), .REDIRECT_BUBBLES(RB)) dut (
    .clock_i(clock), .reset_ni(reset_n), .current_pc_i(pc), .stall_request_i(stall),
    .branch_taken_i(br), .branch_target_i(bt), .jump_valid_i(jv), .jump_target_i(jt),
    .halt_request_i(hr), .resume_i(resume), .control_use_npc_o(use_npc),
    .data_jump_address_o(addr), .flush_o(flush), .fetch_valid_o(fv), .halted_o(halted),
    .stall_cycles_o(stall_cycles), .redirect_count_o(redirect_count)
  );

  always #5 clock = ~clock;

  always @(negedge clock) pc <= use_npc ? pc + 32'd1 : addr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial forever begin
    @(posedge clock);
    if (reset_n) begin
      m_halt = n_halt;
      m_bub = n_bub;
      if (inc_s && e_stall != 32'hFFFF_FFFF) e_stall = e_stall + 32'd1;
      if (inc_r && e_red != 32'hFFFF_FFFF) e_red = e_red + 32'd1;
    end
    #3;
    inc_s = 0;
    inc_r = 0;
    if (!reset_n) begin
      m_halt = 0; n_halt = 0; m_bub = 0; n_bub = 0; e_stall = '0; e_red = '0;
      e_use = 0; e_addr = '0; e_flush = 1; e_fv = 0; e_halted = 0;
    end else if (m_halt) begin
      e_use = 0; e_addr = pc; e_flush = 1; e_fv = 0; e_halted = 1;
      n_halt = !resume; n_bub = 0;
    end else begin
      e_halted = 0;
      n_halt = hr;
      if (br || jv) begin
        e_use = 0; e_addr = br ? bt : jt; e_flush = 1; e_fv = 0; inc_r = 1; n_bub = RB - 1;
      end else begin
        e_flush = m_bub > 0;
        n_bub = m_bub > 0 ? m_bub - 1 : 0;
        if (stall) begin
          e_use = 0; e_addr = pc; e_fv = 0; inc_s = 1;
        end else begin
          e_use = 1; e_addr = '0; e_fv = m_bub == 0;
        end
      end
    end
    chk("use_npc", use_npc, e_use);
    chk("jump_addr", addr, e_addr);
    chk("flush", flush, e_flush);
    chk("fetch_valid", fv, e_fv);
    chk("halted", halted, e_halted);
    chk("stall_cycles", stall_cycles, PERF ? e_stall : 32'd0);
    chk("redirect_count", redirect_count, PERF ? e_red : 32'd0);
  end

  initial begin
    repeat (3) @(posedge clock);
    #1 reset_n = 1'b1;
    #1 chk("s1_fv", fv, 1);
    chk("s1_pc0", pc, 0);
    for (int i = 1; i <= 5; i++) begin
      tick();
      chk("s1_pc", pc, i);
    end
    stall = 1;
    #1 chk("s2_fv_stall", fv, 0);
    chk("s2_use_stall", use_npc, 0);
    tick();
    chk("s2_hold1", pc, 5);
    tick();
    chk("s2_hold2", pc, 5);
    stall = 0;
    tick();
    chk("s2_pc6", pc, 6);
    chk("s2_stall_cnt", stall_cycles, PERF ? 32'd2 : 32'd0);
    tick();
    tick();
    chk("s3_pc8", pc, 8);
    br = 1; bt = 32'h40; jv = 1; jt = 32'h80; stall = 1;
    #1 chk("s3_addr", addr, 32'h40);
    chk("s3_flush0", flush, 1);
    chk("s3_use", use_npc, 0);
    tick();
    br = 0; jv = 0; stall = 0;
    chk("s3_pc40", pc, 32'h40);
    chk("s3_redir_cnt", redirect_count, PERF ? 32'd1 : 32'd0);
    #1 chk("s3_flush1", flush, 1);
    tick();
    chk("s3_pc41", pc, 32'h41);
    #1 chk("s3_flush2", flush, 1);
    tick();
    chk("s3_pc42", pc, 32'h42);
    #1 chk("s3_flush_end", flush, 0);
    chk("s3_fv_end", fv, 1);
    jv = 1; jt = 32'h10;
    tick();
    chk("s4_pc10", pc, 32'h10);
    hr = 1; jt = 32'h20;
    #1 chk("s4_addr", addr, 32'h20);
    tick();
    jv = 0; hr = 0; br = 1; bt = 32'h99;
    chk("s4_pc20", pc, 32'h20);
    #1 chk("s4_halted", halted, 1);
    repeat (4) begin
      tick();
      chk("s4_hold", pc, 32'h20);
      chk("s4_halted_hold", halted, 1);
    end
    tick();
    br = 0; resume = 1; hr = 1;
    chk("s4_pc_pre_resume", pc, 32'h20);
    tick();
    resume = 0; hr = 0;
    chk("s4_pc_resume", pc, 32'h20);
    #1 chk("s4_unhalted", halted, 0);
    chk("s4_fv", fv, 1);
    tick();
    chk("s4_pc21", pc, 32'h21);
    br = 1; bt = 32'h42;
    tick();
    chk("s5_pc42", pc, 32'h42);
    br = 0; reset_n = 0;
    #1 chk("s5_use", use_npc, 0);
    chk("s5_addr", addr, 0);
    chk("s5_flush", flush, 1);
    chk("s5_fv", fv, 0);
    chk("s5_halted", halted, 0);
    chk("s5_redir_cnt", redirect_count, 0);
    repeat (2) @(posedge clock);
    #1 reset_n = 1;
    #1 chk("s5_pc0", pc, 0);
    chk("s5_flush_rel", flush, 0);
    tick();
    chk("s5_pc1", pc, 1);
    tick();
    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
